// File: rtl/vram_arbiter.sv
// Screen-RAM access controller: one access per cycle, fixed priority
// display read > buffered CPU write > hardware fill write.
module vram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic              o_disp_valid,
  output logic [DATA_W-1:0] o_disp_data,
  input  logic              i_cpu_wr_req,
  input  logic [ADDR_W-1:0] i_cpu_wr_addr,
  input  logic [DATA_W-1:0] i_cpu_wr_data,
  output logic              o_cpu_wr_ready,
  input  logic              i_fill_start,
  input  logic [ADDR_W-1:0] i_fill_base,
  input  logic [ADDR_W-1:0] i_fill_len,
  input  logic [DATA_W-1:0] i_fill_data,
  output logic              o_fill_busy,
  output logic              o_fill_done,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_ram_we,
  input  logic [DATA_W-1:0] i_ram_q
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_RUN,
    FILL_DONE
  } fill_state_t;

  logic [ADDR_W-1:0] r_fifoAddr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifoData [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              r_dispValid;

  fill_state_t       r_state;
  fill_state_t       w_nextState;
  logic [ADDR_W-1:0] r_curAddr;
  logic [ADDR_W-1:0] r_remaining;
  logic [DATA_W-1:0] r_fillByte;

  logic w_fifoEmpty;
  logic w_push;
  logic w_pop;
  logic w_fillGrant;

  assign w_fifoEmpty    = (r_count == '0);
  assign o_cpu_wr_ready = (r_count != FULL_CNT);
  assign w_push         = i_cpu_wr_req & o_cpu_wr_ready;
  assign o_disp_valid   = r_dispValid;
  assign o_disp_data    = i_ram_q;

  // Grant is suppressed while reset is held so nothing touches RAM then.
  always_comb begin
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    o_ram_we    = 1'b0;
    w_pop       = 1'b0;
    w_fillGrant = 1'b0;
    if (!i_rst) begin
      if (i_disp_req) begin
        o_ram_addr = i_disp_addr;
      end else if (!w_fifoEmpty) begin
        o_ram_addr  = r_fifoAddr[r_rdPtr];
        o_ram_wdata = r_fifoData[r_rdPtr];
        o_ram_we    = 1'b1;
        w_pop       = 1'b1;
      end else if (r_state == FILL_RUN) begin
        o_ram_addr  = r_curAddr;
        o_ram_wdata = r_fillByte;
        o_ram_we    = 1'b1;
        w_fillGrant = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dispValid <= 1'b0;
    end else begin
      r_dispValid <= i_disp_req;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifoAddr[r_wrPtr] <= i_cpu_wr_addr;
        r_fifoData[r_wrPtr] <= i_cpu_wr_data;
        r_wrPtr             <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= FILL_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Fill parameters are captured only at acceptance; later input changes are ignored.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_curAddr   <= '0;
      r_remaining <= '0;
      r_fillByte  <= '0;
    end else if (r_state == FILL_IDLE && i_fill_start) begin
      r_curAddr   <= i_fill_base;
      r_remaining <= i_fill_len;
      r_fillByte  <= i_fill_data;
    end else if (w_fillGrant) begin
      r_curAddr   <= r_curAddr + ADDR_W'(1);
      r_remaining <= r_remaining - ADDR_W'(1);
    end
  end

  always_comb begin
    w_nextState = r_state;
    o_fill_busy = 1'b0;
    o_fill_done = 1'b0;
    case (r_state)
      FILL_IDLE: begin
        if (i_fill_start) begin
          w_nextState = (i_fill_len == '0) ? FILL_DONE : FILL_RUN;
        end
      end
      FILL_RUN: begin
        o_fill_busy = 1'b1;
        if (w_fillGrant && r_remaining == ADDR_W'(1)) begin
          w_nextState = FILL_DONE;
        end
      end
      FILL_DONE: begin
        o_fill_done = 1'b1;
        w_nextState = FILL_IDLE;
      end
      default: w_nextState = FILL_IDLE;
    endcase
  end

endmodule
